// File: rtl/parser_pkg.sv
// Shared definitions for the if/else parser front end: ASCII constants, the whitespace
// classifier and the feeder FSM state encoding.
package parser_pkg;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_TAB   = 8'h09;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } feeder_state_t;

    function automatic logic is_ws(input logic [7:0] b);
        return (b == CH_SPACE) || (b == CH_TAB) || (b == CH_LF) || (b == CH_CR);
    endfunction

endpackage

// File: rtl/char_stream_feeder_if.sv
// Byte-in / character-out bus of the char stream feeder.
// Handshake: a byte transfers on a rising clk edge where in_valid && in_ready; in_ready never
// depends on in_valid. char_valid is a one-cycle strobe with no back-pressure; ascii_char is
// held between strobes.
interface char_stream_feeder_if;
    logic [7:0] in_byte;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] ascii_char;
    logic       char_valid;

    modport master (
        output in_byte, in_valid,
        input  in_ready, ascii_char, char_valid
    );

    modport slave (
        input  in_byte, in_valid,
        output in_ready, ascii_char, char_valid
    );
endinterface

// File: rtl/char_fifo.sv
// DEPTH x WIDTH FIFO with synchronous flush; a push is refused when full even if a pop
// happens in the same cycle.
module char_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 7
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers are exactly log2(DEPTH) wide, so they wrap without explicit compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/char_stream_feeder.sv
// Buffers text bytes and re-times them as single-cycle char_valid pulses separated by
// GAP_CYCLES idle cycles. Optional macro WS_COLLAPSE_EN collapses whitespace runs to one space.
module char_stream_feeder
    import parser_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int GAP_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    char_stream_feeder_if.slave  bus,
    input  logic                 flush,
    output logic                 busy,
    output logic                 bad_char,
    output feeder_state_t        fsm_state
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    generate
        if (GAP_CYCLES < 1) begin : g_bad_gap
            $error("char_stream_feeder: GAP_CYCLES must be >= 1");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("char_stream_feeder: DEPTH must be a power of 2 and >= 2");
        end
    endgenerate

    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic [6:0]    fifo_rdata;
    logic          accept;
    logic          wr_en;
    logic [6:0]    wr_data;
    logic          pop;
    feeder_state_t state;
    feeder_state_t state_n;
    logic [GW-1:0] gap_cnt;
    logic [GW-1:0] gap_n;
    logic [6:0]    ascii_q;

    assign bus.in_ready = !full && !flush;
    assign accept       = bus.in_valid && bus.in_ready;

`ifdef WS_COLLAPSE_EN
    logic last_ws;
    logic in_ws;

    assign in_ws   = is_ws(bus.in_byte);
    assign wr_en   = accept && !bus.in_byte[7] && !(in_ws && last_ws);
    assign wr_data = in_ws ? CH_SPACE[6:0] : bus.in_byte[6:0];

    // Dropped high-bit bytes leave the whitespace history untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_ws <= 1'b0;
        end else if (flush) begin
            last_ws <= 1'b0;
        end else if (accept && !bus.in_byte[7]) begin
            last_ws <= in_ws;
        end
    end
`else
    assign wr_en   = accept && !bus.in_byte[7];
    assign wr_data = bus.in_byte[6:0];
`endif

    char_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (7)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_en),
        .pop   (pop),
        .flush (flush),
        .wdata (wr_data),
        .rdata (fifo_rdata),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        state_n = state;
        gap_n   = gap_cnt;
        pop     = 1'b0;
        if (flush) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_n = ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    gap_n   = GW'(GAP_CYCLES - 1);
                    state_n = ST_GAP;
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        if (!empty) begin
                            pop     = 1'b1;
                            state_n = ST_PULSE;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end else begin
                        gap_n = gap_cnt - 1'b1;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            gap_cnt  <= '0;
            ascii_q  <= '0;
            bad_char <= 1'b0;
        end else begin
            state   <= state_n;
            gap_cnt <= gap_n;
            if (pop) ascii_q <= fifo_rdata;
            if (accept && bus.in_byte[7]) bad_char <= 1'b1;
        end
    end

    // char_valid comes straight off the state register so an async reset drops it at once.
    assign bus.char_valid = (state == ST_PULSE);
    assign bus.ascii_char = ascii_q;
    assign busy           = (count != '0) || (state != ST_IDLE);
    assign fsm_state      = state;

endmodule
